redmule_instr_axi_responder: RTL and testbench

REDMULE_INSTR_AXI_RESPONDER -- requirements
Module: redmule_instr_axi_responder

---
 rtl/redmule_instr_axi_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_redmule_instr_axi_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_instr_axi_responder.sv
`default_nettype none
// ============================================================================
// Module      : redmule_instr_axi_responder
// Description : Read-only AXI4 slave serving 32-bit instruction words from an
//               internal memory.
//               - Reads: single outstanding burst; FIXED, INCR and WRAP bursts.
//               - Writes: accepted and drained, then answered with SLVERR.
//               - Preload: a backdoor port fills the memory.
//               Optional feature macro: REDMULE_INSTR_RESP_RANGE_CHECK_EN
//               (return DECERR for beats whose address is beyond the memory).
// Revision    : 1.0 - initial release
// ============================================================================
module redmule_instr_axi_responder #(
    parameter int unsigned N_WORDS = 4096,
    parameter int unsigned ID_W    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // read address channel
    input  logic                       ar_valid_i,
    output logic                       ar_ready_o,
    input  logic [ID_W-1:0]            ar_id_i,
    input  logic [31:0]                ar_addr_i,
    input  logic [7:0]                 ar_len_i,
    input  logic [2:0]                 ar_size_i,
    input  logic [1:0]                 ar_burst_i,
    // read data channel
    output logic                       r_valid_o,
    input  logic                       r_ready_i,
    output logic [ID_W-1:0]            r_id_o,
    output logic [31:0]                r_data_o,
    output logic [1:0]                 r_resp_o,
    output logic                       r_last_o,
    // write channels (always rejected)
    input  logic                       aw_valid_i,
    output logic                       aw_ready_o,
    input  logic [ID_W-1:0]            aw_id_i,
    input  logic                       w_valid_i,
    output logic                       w_ready_o,
    input  logic                       w_last_i,
    output logic                       b_valid_o,
    input  logic                       b_ready_i,
    output logic [ID_W-1:0]            b_id_o,
    output logic [1:0]                 b_resp_o,
    // backdoor preload
    input  logic                       load_en_i,
    input  logic [$clog2(N_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                load_data_i
);

    localparam int unsigned AW         = $clog2(N_WORDS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;
    localparam logic [1:0]  BURST_RSVD  = 2'b11;
    localparam logic [2:0]  SIZE_WORD   = 3'b010;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem [N_WORDS];

    // Backdoor preload; memory has no reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t    r_state;
    r_state_t    r_state_next;
    logic        ar_hs;
    logic        r_hs;
    logic        ar_err;

    // Full 30-bit word address is tracked so an out-of-range beat can be
    // detected; the memory index uses only the low AW bits.
    logic [29:0] cur_addr;
    logic [29:0] next_addr;
    logic [29:0] fetch_addr;
    logic        fetch_err;
    logic [31:0] fetch_data;
    logic [1:0]  fetch_resp;
    logic [29:0] wrap_mask;

    logic [7:0]  len_q;
    logic [7:0]  beat_cnt;
    logic [1:0]  burst_q;
    logic        err_q;

    assign ar_hs      = (r_state == R_IDLE) && ar_valid_i;
    assign r_hs       = (r_state == R_BURST) && r_ready_i;
    assign ar_ready_o = (r_state == R_IDLE);
    assign r_valid_o  = (r_state == R_BURST);

    // Unsupported size, reserved burst type or illegal WRAP length -> SLVERR burst.
    always_comb begin
        ar_err = 1'b0;
        if (ar_size_i != SIZE_WORD) begin
            ar_err = 1'b1;
        end
        if (ar_burst_i == BURST_RSVD) begin
            ar_err = 1'b1;
        end
        if ((ar_burst_i == BURST_WRAP) &&
            !((ar_len_i == 8'd1) || (ar_len_i == 8'd3) ||
              (ar_len_i == 8'd7) || (ar_len_i == 8'd15))) begin
            ar_err = 1'b1;
        end
    end

    // Address of the beat following the current one.
    always_comb begin
        wrap_mask = {22'd0, len_q};
        case (burst_q)
            BURST_FIXED: next_addr = cur_addr;
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) |
                                     ((cur_addr + 30'd1) & wrap_mask);
            default:     next_addr = cur_addr + 30'd1;
        endcase
    end

    // Beat to be loaded into the output registers at the next handshake:
    // the first beat on AR, otherwise the following beat.
    always_comb begin
        fetch_addr = ar_hs ? ar_addr_i[31:2] : next_addr;
        fetch_err  = ar_hs ? ar_err : err_q;
        fetch_data = mem[fetch_addr[AW-1:0]];
        fetch_resp = RESP_OKAY;
        if (fetch_err) begin
            fetch_data = 32'd0;
            fetch_resp = RESP_SLVERR;
        end
`ifdef REDMULE_INSTR_RESP_RANGE_CHECK_EN
        else if (fetch_addr[29:AW] != '0) begin
            fetch_data = 32'd0;
            fetch_resp = 2'b11;
        end
`endif
    end

`ifdef REDMULE_INSTR_RESP_RANGE_CHECK_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^ar_addr_i[1:0];
`else
    // Without the range check the upper address bits simply wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ar_addr_i[1:0], fetch_addr[29:AW]};
`endif

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Read FSM next state: one burst at a time, leave on the last handshake.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_valid_i) r_state_next = R_BURST;
            R_BURST: if (r_ready_i && r_last_o) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Burst context and registered beat outputs; held steady while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_addr <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            beat_cnt <= '0;
            r_id_o   <= '0;
            r_data_o <= '0;
            r_resp_o <= '0;
            r_last_o <= 1'b0;
        end else if (ar_hs) begin
            cur_addr <= ar_addr_i[31:2];
            len_q    <= ar_len_i;
            burst_q  <= ar_burst_i;
            err_q    <= ar_err;
            beat_cnt <= '0;
            r_id_o   <= ar_id_i;
            r_data_o <= fetch_data;
            r_resp_o <= fetch_resp;
            r_last_o <= (ar_len_i == 8'd0);
        end else if (r_hs) begin
            if (r_last_o) begin
                r_data_o <= '0;
                r_resp_o <= '0;
                r_last_o <= 1'b0;
            end else begin
                cur_addr <= next_addr;
                beat_cnt <= beat_cnt + 8'd1;
                r_data_o <= fetch_data;
                r_resp_o <= fetch_resp;
                r_last_o <= ((beat_cnt + 8'd1) == len_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel: drain and reject
    // ------------------------------------------------------------------
    w_state_t w_state;
    w_state_t w_state_next;

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // Write FSM next state and channel handshakes.
    always_comb begin
        w_state_next = w_state;
        aw_ready_o   = 1'b0;
        w_ready_o    = 1'b0;
        b_valid_o    = 1'b0;
        b_resp_o     = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_valid_i) w_state_next = W_DATA;
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) w_state_next = W_RESP;
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                b_resp_o  = RESP_SLVERR;
                if (b_ready_i) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Capture the write ID for the B response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_id_o <= '0;
        end else if ((w_state == W_IDLE) && aw_valid_i) begin
            b_id_o <= aw_id_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_redmule_instr_axi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_redmule_instr_axi_responder
// Description : Self-checking bench for redmule_instr_axi_responder with a
//               behavioural memory/burst model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redmule_instr_axi_responder;

    localparam int N    = 4096;
    localparam int ID_W = 4;
    localparam int AW   = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_i;
    logic            ar_valid_i, ar_ready_o;
    logic [ID_W-1:0] ar_id_i;
    logic [31:0]     ar_addr_i;
    logic [7:0]      ar_len_i;
    logic [2:0]      ar_size_i;
    logic [1:0]      ar_burst_i;
    logic            r_valid_o, r_ready_i;
    logic [ID_W-1:0] r_id_o;
    logic [31:0]     r_data_o;
    logic [1:0]      r_resp_o;
    logic            r_last_o;
    logic            aw_valid_i, aw_ready_o;
    logic [ID_W-1:0] aw_id_i;
    logic            w_valid_i, w_ready_o, w_last_i;
    logic            b_valid_o, b_ready_i;
    logic [ID_W-1:0] b_id_o;
    logic [1:0]      b_resp_o;
    logic            load_en_i;
    logic [AW-1:0]   load_addr_i;
    logic [31:0]     load_data_i;

    always #5 clk = ~clk;

    redmule_instr_axi_responder #(.N_WORDS(N), .ID_W(ID_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
        .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
        .ar_burst_i(ar_burst_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
        .b_resp_o(b_resp_o),
        .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what beat i of a burst should carry, from the AXI rules.
    function automatic void exp_beat(input logic [31:0] addr, input int len,
                                     input logic [1:0] burst, input logic [2:0] size,
                                     input int i, output logic [31:0] d,
                                     output logic [1:0] resp);
        longint w0, w;
        int     n;
        n  = len + 1;
        w0 = longint'(addr) / 4;
        if (size != 3'd2 || burst == 2'd3 || (burst == 2'd2 && !(n inside {2, 4, 8, 16}))) begin
            d = 0; resp = 2'b10;
            return;
        end
        if (burst == 2'd0)      w = w0;
        else if (burst == 2'd1) w = w0 + i;
        else                    w = (w0 - (w0 % n)) + ((w0 % n) + i) % n;
`ifdef REDMULE_INSTR_RESP_RANGE_CHECK_EN
        if (w >= N) begin
            d = 0; resp = 2'b11;
            return;
        end
`endif
        d    = model_mem[int'(w % N)];
        resp = 2'b00;
    endfunction

    task automatic preload(input int w, input logic [31:0] d);
        load_en_i   = 1'b1;
        load_addr_i = w[AW-1:0];
        load_data_i = d;
        @(negedge clk);
        load_en_i   = 1'b0;
        model_mem[w] = d;
    endtask

    // mode 0: always ready; 1: pattern 1,0,0,1; 2: random with bounded stall
    task automatic read_burst(input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic [2:0] size,
                              input logic [ID_W-1:0] id, input int mode, input string tag);
        logic [31:0] ed;
        logic [1:0]  er;
        logic        rdy;
        int          cyc;
        int          stalls;
        cyc = 0;
        ar_addr_i = addr; ar_len_i = len[7:0]; ar_burst_i = burst;
        ar_size_i = size; ar_id_i = id; ar_valid_i = 1'b1;
        check({tag, " ar_ready"}, 32'(ar_ready_o), 32'd1);
        @(negedge clk);
        ar_valid_i = 1'b0;
        for (int i = 0; i <= len; i++) begin
            exp_beat(addr, len, burst, size, i, ed, er);
            stalls = 0;
            forever begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: rdy = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                endcase
                cyc++;
                r_ready_i = rdy;
                check($sformatf("%s b%0d valid", tag, i), 32'(r_valid_o), 32'd1);
                check($sformatf("%s b%0d data", tag, i), r_data_o, ed);
                check($sformatf("%s b%0d resp", tag, i), 32'(r_resp_o), 32'(er));
                check($sformatf("%s b%0d id", tag, i), 32'(r_id_o), 32'(id));
                check($sformatf("%s b%0d last", tag, i), 32'(r_last_o), 32'(i == len));
                @(negedge clk);
                if (rdy) break;
                stalls++;
            end
        end
        r_ready_i = 1'b0;
        check({tag, " end valid"}, 32'(r_valid_o), 32'd0);
        check({tag, " end ar_ready"}, 32'(ar_ready_o), 32'd1);
    endtask

    task automatic write_reject(input logic [ID_W-1:0] id, input int nbeats, input string tag);
        aw_id_i = id; aw_valid_i = 1'b1;
        check({tag, " aw_ready"}, 32'(aw_ready_o), 32'd1);
        @(negedge clk);
        aw_valid_i = 1'b0;
        check({tag, " aw_ready busy"}, 32'(aw_ready_o), 32'd0);
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                w_valid_i = 1'b0;
                @(negedge clk);
            end
            w_valid_i = 1'b1;
            w_last_i  = (b == nbeats - 1);
            check($sformatf("%s w%0d w_ready", tag, b), 32'(w_ready_o), 32'd1);
            check($sformatf("%s w%0d b_valid", tag, b), 32'(b_valid_o), 32'd0);
            @(negedge clk);
        end
        w_valid_i = 1'b0; w_last_i = 1'b0;
        b_ready_i = 1'b0;
        check({tag, " b_valid"}, 32'(b_valid_o), 32'd1);
        check({tag, " b_resp"}, 32'(b_resp_o), 32'd2);
        check({tag, " b_id"}, 32'(b_id_o), 32'(id));
        check({tag, " w_ready off"}, 32'(w_ready_o), 32'd0);
        @(negedge clk);
        check({tag, " b_valid held"}, 32'(b_valid_o), 32'd1);
        b_ready_i = 1'b1;
        @(negedge clk);
        b_ready_i = 1'b0;
        check({tag, " b_valid done"}, 32'(b_valid_o), 32'd0);
        check({tag, " aw_ready back"}, 32'(aw_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        int          ln;
        logic [1:0]  bt;
        logic [2:0]  sz;
        rst_i = 1'b1;
        ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 3'd2;
        ar_burst_i = 2'd1; r_ready_i = 0; aw_valid_i = 0; aw_id_i = 0;
        w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
        load_en_i = 0; load_addr_i = 0; load_data_i = 0;
        for (int k = 0; k < N; k++) model_mem[k] = 32'd0;
        #2;
        check("rst ar_ready", 32'(ar_ready_o), 32'd1);
        check("rst aw_ready", 32'(aw_ready_o), 32'd1);
        check("rst r_valid",  32'(r_valid_o),  32'd0);
        check("rst r_last",   32'(r_last_o),   32'd0);
        check("rst r_data",   r_data_o,        32'd0);
        check("rst r_resp",   32'(r_resp_o),   32'd0);
        check("rst r_id",     32'(r_id_o),     32'd0);
        check("rst w_ready",  32'(w_ready_o),  32'd0);
        check("rst b_valid",  32'(b_valid_o),  32'd0);
        check("rst b_resp",   32'(b_resp_o),   32'd0);
        check("rst b_id",     32'(b_id_o),     32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Whole memory zeroed so wrapped/out-of-range reads are defined.
        for (int k = 0; k < N; k++) preload(k, 32'd0);

        // Basic INCR burst, then with 1,0,0,1 backpressure.
        preload(0, 32'h13); preload(1, 32'h93); preload(2, 32'h113); preload(3, 32'h193);
        read_burst(32'h0, 3, 2'd1, 3'd2, 4'd5, 0, "incr");
        read_burst(32'h0, 3, 2'd1, 3'd2, 4'd5, 1, "incr_stall");
        read_burst(32'h2, 3, 2'd1, 3'd2, 4'd6, 0, "incr_unaligned");

        // WRAP: aligned 4-word window around word 4 and word 6.
        for (int k = 2; k < 8; k++) preload(k, 32'hA000_0000 + 32'(k));
        read_burst(32'h10, 3, 2'd2, 3'd2, 4'd1, 0, "wrap4");
        read_burst(32'h18, 3, 2'd2, 3'd2, 4'd1, 1, "wrap4_mid");
        read_burst(32'h10, 2, 2'd2, 3'd2, 4'd2, 0, "wrap_badlen");
        read_burst(32'h10, 1, 2'd3, 3'd2, 4'd3, 0, "rsvd_burst");
        read_burst(32'h10, 2, 2'd1, 3'd1, 4'd4, 0, "bad_size");
        read_burst(32'h14, 2, 2'd0, 3'd2, 4'd7, 0, "fixed");

        // Writes are rejected and never touch memory.
        write_reject(4'd2, 3, "wr");
        check("wr ar_ready indep", 32'(ar_ready_o), 32'd1);
        read_burst(32'h0, 7, 2'd1, 3'd2, 4'd2, 0, "after_wr");
        write_reject(4'd9, 1, "wr1");

        // Top of memory / beyond it.
        for (int k = N - 8; k < N; k++) preload(k, $urandom);
        read_burst(32'(4 * (N - 3)), 7, 2'd1, 3'd2, 4'd8, 0, "top_cross");
        read_burst(32'h4000, 0, 2'd1, 3'd2, 4'd9, 0, "range");

        // Load in the same cycle as the AR handshake: old data returned.
        preload(41, 32'hC0DE_0001);
        ar_addr_i = 32'(41 * 4); ar_len_i = 0; ar_burst_i = 2'd1; ar_size_i = 3'd2;
        ar_id_i = 4'd3; ar_valid_i = 1'b1;
        load_en_i = 1'b1; load_addr_i = AW'(41); load_data_i = 32'hC0DE_0002;
        @(negedge clk);
        ar_valid_i = 1'b0; load_en_i = 1'b0;
        check("same_cycle old", r_data_o, 32'hC0DE_0001);
        r_ready_i = 1'b1;
        @(negedge clk);
        r_ready_i = 1'b0;
        model_mem[41] = 32'hC0DE_0002;
        read_burst(32'(41 * 4), 0, 2'd1, 3'd2, 4'd3, 0, "same_cycle new");

        // Reset during beat 2 of a len-7 burst.
        ar_addr_i = 32'h0; ar_len_i = 8'd7; ar_burst_i = 2'd1; ar_size_i = 3'd2;
        ar_id_i = 4'd11; ar_valid_i = 1'b1;
        @(negedge clk);
        ar_valid_i = 1'b0;
        r_ready_i = 1'b1;
        check("mrst b0 data", r_data_o, model_mem[0]);
        @(negedge clk);
        r_ready_i = 1'b0;
        check("mrst b1 data", r_data_o, model_mem[1]);
        rst_i = 1'b1;
        #1;
        check("mrst r_valid", 32'(r_valid_o), 32'd0);
        check("mrst r_last",  32'(r_last_o),  32'd0);
        check("mrst r_data",  r_data_o,       32'd0);
        check("mrst r_id",    32'(r_id_o),    32'd0);
        check("mrst ar_ready", 32'(ar_ready_o), 32'd1);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("mrst post valid", 32'(r_valid_o), 32'd0);
        check("mrst post ar_ready", 32'(ar_ready_o), 32'd1);
        read_burst(32'h0, 3, 2'd1, 3'd2, 4'd12, 0, "post_rst");

        // Randomized bursts against the model.
        for (int k = 0; k < 128; k++) preload(k, $urandom);
        for (int t = 0; t < 40; t++) begin
            a  = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            ln = $urandom_range(0, 15);
            bt = 2'($urandom_range(0, 3));
            if (bt == 2'd2 && $urandom_range(0, 3) != 0) ln = (2 << $urandom_range(0, 3)) - 1;
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            read_burst(a, ln, bt, sz, 4'($urandom), 2, $sformatf("rnd%0d", t));
            if (t % 8 == 0) write_reject(4'($urandom), $urandom_range(1, 4), "rnd_wr");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
